fetch_unit: RTL

Instruction-fetch stage of the five-stage pipeline. It owns the PC, issues word requests to instruction memory over a req/gnt + rvalid handshake, and buffers returned words in a 2-entry queue feeding the decode stage. It consumes the decoder's next-PC selection (`npcOp`) and branch outcome, and redirects fetch by flushing queued and in-flight instructions.

---
 rtl/fetch_unit_pkg.sv | 30 +++
 rtl/fetch_queue.sv | 58 +++++
 rtl/fetch_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types: next-PC opcodes (common with the decoder), queue entry and FSM state.
package fetch_unit_pkg;

    localparam int unsigned NPC_OP_LENGTH = 2;

    typedef enum logic [NPC_OP_LENGTH-1:0] {
        NPC_OP_PLUS4  = 2'b00,
        NPC_OP_JUMP   = 2'b01,
        NPC_OP_BRANCH = 2'b10
    } npc_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        StRun,
        StDrain
    } fetch_state_e;

    function automatic logic [31:0] branch_target(input logic [31:0] pc4, input logic [15:0] imm);
        return pc4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [25:0] idx);
        return {pc4[31:28], idx, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, instr} between the imem response port and decode; registered head.
module fetch_queue
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         wr_ptr;
    logic         do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && (count_q != 2'd0);
        // A full queue still accepts a push when the head leaves in the same cycle.
        do_push  = push_i && ((count_q != 2'd2) || do_pop);
        wr_ptr   = rd_ptr_q ^ count_q[0];
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) mem_d[wr_ptr] = push_entry_i;
            if (do_pop) rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, imem req/gnt/rvalid handshake, 2-entry queue, redirect with discard.
// Optional FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_3000,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [31:0]              imem_rdata,
    output logic [31:0]              instrD,
    output logic [31:0]              pcD,
    output logic                     instrD_valid,
    input  logic                     instrD_ready,
    input  logic                     dec_fire,
    input  logic [NPC_OP_LENGTH-1:0] npcOp,
    input  logic                     isTaken,
    input  logic [31:0]              pcD4,
    input  logic [15:0]              imm16,
`ifdef FETCH_PERF_EN
    output logic [31:0]              perf_fetched,
    output logic [31:0]              perf_flushed,
`endif
    input  logic [25:0]              jidx26
);

    localparam logic [1:0] MaxOut = 2'(MAX_OUTSTANDING);

    logic [31:0]  fpc_q, fpc_d;
    logic [31:0]  rpc_q, rpc_d;
    logic [1:0]   out_q, out_d;
    logic [1:0]   discard_q, discard_d;
    fetch_state_e state_q, state_d;

    logic         redirect, grant, push, drop, q_pop, q_full, q_empty;
    logic [1:0]   occ;
    logic [2:0]   inflight;
    logic [31:0]  target;
    fetch_entry_t head, push_entry;

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, fetched_d, flushed_q, flushed_d;
`endif

    always_comb begin
        redirect = dec_fire && ((npcOp == NPC_OP_JUMP) || ((npcOp == NPC_OP_BRANCH) && isTaken));
        target   = (npcOp == NPC_OP_JUMP) ? jump_target(pcD4, jidx26) : branch_target(pcD4, imm16);

        occ      = q_full ? 2'd2 : (q_empty ? 2'd0 : 2'd1);
        q_pop    = !q_empty && instrD_ready;
        // Counting the slot freed by this cycle's pop keeps a 1-per-cycle stream at 1-cycle latency.
        inflight = {1'b0, out_q} + {1'b0, occ} - {2'b0, q_pop};
        imem_req = !rst && (inflight < 3'd2) && (out_q < MaxOut);
        grant    = imem_req && imem_gnt;

        drop     = imem_rvalid && (redirect || (state_q == StDrain));
        push     = imem_rvalid && !drop;
        push_entry.pc    = rpc_q;
        push_entry.instr = imem_rdata;

        out_d = out_q;
        unique case ({grant, imem_rvalid})
            2'b10:   out_d = out_q + 2'd1;
            2'b01:   out_d = out_q - 2'd1;
            default: out_d = out_q;
        endcase

        // Everything still outstanding after this cycle belongs to the abandoned path.
        discard_d = discard_q;
        if (redirect) discard_d = out_d;
        else if (drop) discard_d = discard_q - 2'd1;
        state_d = (discard_d != 2'd0) ? StDrain : StRun;

        fpc_d = fpc_q;
        if (redirect) fpc_d = target;
        else if (grant) fpc_d = fpc_q + 32'd4;

        rpc_d = rpc_q;
        if (redirect) rpc_d = target;
        else if (push) rpc_d = rpc_q + 32'd4;

`ifdef FETCH_PERF_EN
        fetched_d = fetched_q + {31'b0, push};
        flushed_d = flushed_q + {31'b0, drop} + (redirect ? {30'b0, occ} : 32'd0);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q     <= RESET_PC;
            rpc_q     <= RESET_PC;
            out_q     <= 2'd0;
            discard_q <= 2'd0;
            state_q   <= StRun;
`ifdef FETCH_PERF_EN
            fetched_q <= 32'd0;
            flushed_q <= 32'd0;
`endif
        end else begin
            fpc_q     <= fpc_d;
            rpc_q     <= rpc_d;
            out_q     <= out_d;
            discard_q <= discard_d;
            state_q   <= state_d;
`ifdef FETCH_PERF_EN
            fetched_q <= fetched_d;
            flushed_q <= flushed_d;
`endif
        end
    end

    fetch_queue u_queue (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (q_pop),
        .flush_i      (redirect),
        .head_o       (head),
        .full_o       (q_full),
        .empty_o      (q_empty)
    );

    assign imem_addr    = fpc_q;
    assign instrD       = head.instr;
    assign pcD          = head.pc;
    assign instrD_valid = !q_empty;

`ifdef FETCH_PERF_EN
    assign perf_fetched = fetched_q;
    assign perf_flushed = flushed_q;
`endif

endmodule
